// File: rtl/unet_fmap_buffer_if.sv
// Bus bundle between a UNET layer IP / host pair and the ping-pong
// feature-map buffer. The master side is the IP plus host, and the slave
// side is the buffer.
interface unet_fmap_buffer_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
);
    // IP read port (IN bank)
    logic [ADDR_W-1:0] in_radr;
    logic              in_re;
    logic              in_clken;
    logic [DATA_W-1:0] in_q;
    logic              in_triosy_lz;

    // IP write port (OUT bank)
    logic [ADDR_W-1:0] out_wadr;
    logic [DATA_W-1:0] out_d;
    logic              out_we;
    logic              out_clken;
    logic              out_triosy_lz;

    // Host load stream into the IN bank
    logic              ld_start;
    logic [ADDR_W:0]   ld_len;
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;

    // Host drain stream out of the OUT bank
    logic              dr_start;
    logic [ADDR_W:0]   dr_len;
    logic              dr_valid;
    logic              dr_ready;
    logic [DATA_W-1:0] dr_data;

    // Control and status
    logic              swap;
    logic              bank_sel;
    logic              busy;
    logic              layer_done;
    logic              err;

    modport master (
        output in_radr, in_re, in_clken, in_triosy_lz,
        output out_wadr, out_d, out_we, out_clken, out_triosy_lz,
        output ld_start, ld_len, ld_valid, ld_data,
        output dr_start, dr_len, dr_ready,
        output swap,
        input  in_q, ld_ready, dr_valid, dr_data,
        input  bank_sel, busy, layer_done, err
    );

    modport slave (
        input  in_radr, in_re, in_clken, in_triosy_lz,
        input  out_wadr, out_d, out_we, out_clken, out_triosy_lz,
        input  ld_start, ld_len, ld_valid, ld_data,
        input  dr_start, dr_len, dr_ready,
        input  swap,
        output in_q, ld_ready, dr_valid, dr_data,
        output bank_sel, busy, layer_done, err
    );
endinterface

// File: rtl/unet_fmap_buffer.sv
// Ping-pong feature-map buffer for a UNET layer IP.
// There are two 1W1R banks. The IN bank serves the IP read port and is filled
// by the host load stream. The OUT bank absorbs IP writes and is emptied by the
// host drain stream. A swap exchanges the two roles, so a layer's output becomes
// the next layer's input without any copy.
// Optional feature: define UNET_FMAP_BUF_BOUNDS_EN to check addresses and
// lengths against DEPTH. A failed check raises the sticky err flag.
module unet_fmap_buffer #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 24576
) (
    input logic               clk,
    input logic               rst,
    unet_fmap_buffer_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W:0]   ld_cnt;
    logic [ADDR_W:0]   ld_len_q;
    logic [ADDR_W:0]   dr_rd_cnt;
    logic [ADDR_W:0]   dr_pop_cnt;
    logic [ADDR_W:0]   dr_len_q;

    logic              bank_sel_q;
    logic              swap_pending;
    logic              layer_done_q;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];

    logic [DATA_W-1:0] in_q_q;
    logic [DATA_W-1:0] skid [2];
    logic              skid_wp;
    logic              skid_rp;
    logic [1:0]        skid_cnt;

    // The IP input-done pulse is observed only. It has no effect on state.
    logic              unused_in_done;
    assign unused_in_done = bus.in_triosy_lz;

    // Qualified IP accesses
    logic ip_rd;
    logic ip_wr;
    assign ip_rd = bus.in_re & bus.in_clken;
    assign ip_wr = bus.out_we & bus.out_clken;

    logic ip_rd_oob;
    logic ip_wr_oob;
    logic ld_len_bad;
    logic dr_len_bad;

`ifdef UNET_FMAP_BUF_BOUNDS_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    assign ip_rd_oob  = ip_rd & ({1'b0, bus.in_radr} >= DEPTH_L);
    assign ip_wr_oob  = ip_wr & ({1'b0, bus.out_wadr} >= DEPTH_L);
    assign ld_len_bad = bus.ld_len > DEPTH_L;
    assign dr_len_bad = bus.dr_len > DEPTH_L;
`else
    assign ip_rd_oob  = 1'b0;
    assign ip_wr_oob  = 1'b0;
    assign ld_len_bad = 1'b0;
    assign dr_len_bad = 1'b0;
`endif

    logic ip_wr_ok;
    assign ip_wr_ok = ip_wr & ~ip_wr_oob;

    // Command decode in IDLE. The priority is swap, then load, then drain.
    logic idle;
    logic do_load;
    logic do_drain;
    logic len_err;
    assign idle     = (state == ST_IDLE);
    assign do_load  = idle & ~bus.swap & bus.ld_start & (bus.ld_len != '0) & ~ld_len_bad;
    assign do_drain = idle & ~bus.swap & ~bus.ld_start & bus.dr_start
                      & (bus.dr_len != '0) & ~dr_len_bad;
    assign len_err  = idle & ~bus.swap & ((bus.ld_start & ld_len_bad)
                      | (~bus.ld_start & bus.dr_start & dr_len_bad));

    // Load stream
    logic ld_fire;
    logic ld_last;
    assign ld_fire = (state == ST_LOAD) & bus.ld_valid;
    assign ld_last = ld_fire & (ld_cnt == ld_len_q - 1'b1);

    // Drain stream. A read lands in the skid at the next edge, so one read is
    // issued only when a slot is free after any pop in the same cycle.
    logic dr_pop;
    logic dr_issue;
    logic dr_last;
    assign dr_pop   = (skid_cnt != 2'd0) & bus.dr_ready;
    assign dr_issue = (state == ST_DRAIN) & (dr_rd_cnt != dr_len_q)
                      & ((skid_cnt != 2'd2) | dr_pop);
    assign dr_last  = dr_pop & (dr_pop_cnt == dr_len_q - 1'b1);

    logic to_idle;
    logic swap_apply;
    assign to_idle    = ld_last | dr_last;
    assign swap_apply = (idle & bus.swap) | (to_idle & (bus.swap | swap_pending));

    // Per-bank write port steering. The IN bank takes load words and the OUT
    // bank takes IP writes.
    logic              a_we;
    logic              b_we;
    logic [ADDR_W-1:0] a_wadr;
    logic [ADDR_W-1:0] b_wadr;
    logic [DATA_W-1:0] a_wd;
    logic [DATA_W-1:0] b_wd;
    logic [ADDR_W-1:0] ld_wadr;
    assign ld_wadr = ld_cnt[ADDR_W-1:0];
    assign a_we    = bank_sel_q ? ip_wr_ok     : ld_fire;
    assign a_wadr  = bank_sel_q ? bus.out_wadr : ld_wadr;
    assign a_wd    = bank_sel_q ? bus.out_d    : bus.ld_data;
    assign b_we    = bank_sel_q ? ld_fire      : ip_wr_ok;
    assign b_wadr  = bank_sel_q ? ld_wadr      : bus.out_wadr;
    assign b_wd    = bank_sel_q ? bus.ld_data  : bus.out_d;

    // Per-bank read port steering. The IN bank serves the IP and the OUT bank
    // serves the drain.
    logic [ADDR_W-1:0] dr_radr;
    logic [DATA_W-1:0] in_rd_data;
    logic [DATA_W-1:0] out_rd_data;
    assign dr_radr     = dr_rd_cnt[ADDR_W-1:0];
    assign in_rd_data  = bank_sel_q ? mem_b[bus.in_radr] : mem_a[bus.in_radr];
    assign out_rd_data = bank_sel_q ? mem_a[dr_radr]     : mem_b[dr_radr];

    // Bank A storage. It is not reset, so contents survive reset and swaps.
    always_ff @(posedge clk) begin
        if (a_we)
            mem_a[a_wadr] <= a_wd;
    end

    // Bank B storage. It is not reset, so contents survive reset and swaps.
    always_ff @(posedge clk) begin
        if (b_we)
            mem_b[b_wadr] <= b_wd;
    end

    // Registered IP read data. It holds its value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            in_q_q <= '0;
        else if (ip_rd)
            in_q_q <= ip_rd_oob ? '0 : in_rd_data;
    end

    // Transfer FSM and the load/drain counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            ld_cnt     <= '0;
            ld_len_q   <= '0;
            dr_rd_cnt  <= '0;
            dr_pop_cnt <= '0;
            dr_len_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (do_load) begin
                        state    <= ST_LOAD;
                        ld_cnt   <= '0;
                        ld_len_q <= bus.ld_len;
                    end else if (do_drain) begin
                        state      <= ST_DRAIN;
                        dr_rd_cnt  <= '0;
                        dr_pop_cnt <= '0;
                        dr_len_q   <= bus.dr_len;
                    end
                end
                ST_LOAD: begin
                    if (ld_fire) begin
                        ld_cnt <= ld_cnt + 1'b1;
                        if (ld_last)
                            state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (dr_issue)
                        dr_rd_cnt <= dr_rd_cnt + 1'b1;
                    if (dr_pop) begin
                        dr_pop_cnt <= dr_pop_cnt + 1'b1;
                        if (dr_last)
                            state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Two-entry drain skid buffer, filled directly by OUT-bank reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid[0]  <= '0;
            skid[1]  <= '0;
            skid_wp  <= 1'b0;
            skid_rp  <= 1'b0;
            skid_cnt <= 2'd0;
        end else begin
            if (dr_issue) begin
                skid[skid_wp] <= out_rd_data;
                skid_wp       <= ~skid_wp;
            end
            if (dr_pop)
                skid_rp <= ~skid_rp;
            skid_cnt <= skid_cnt + {1'b0, dr_issue} - {1'b0, dr_pop};
        end
    end

    // Bank role swap. A swap requested mid-transfer waits until the FSM
    // returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_sel_q   <= 1'b0;
            swap_pending <= 1'b0;
        end else if (swap_apply) begin
            bank_sel_q   <= ~bank_sel_q;
            swap_pending <= 1'b0;
        end else if (!idle && bus.swap) begin
            swap_pending <= 1'b1;
        end
    end

    // Sticky layer-done flag. It is set by the IP output-done pulse and
    // cleared by a swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            layer_done_q <= 1'b0;
        else if (bus.out_triosy_lz)
            layer_done_q <= 1'b1;
        else if (swap_apply)
            layer_done_q <= 1'b0;
    end

`ifdef UNET_FMAP_BUF_BOUNDS_EN
    logic err_q;

    // Sticky bounds error. Only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (ip_rd_oob || ip_wr_oob || len_err)
            err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    logic unused_len_err;
    assign unused_len_err = len_err;
    assign bus.err        = 1'b0;
`endif

    assign bus.in_q       = in_q_q;
    assign bus.ld_ready   = (state == ST_LOAD);
    assign bus.dr_valid   = (skid_cnt != 2'd0);
    assign bus.dr_data    = skid[skid_rp];
    assign bus.bank_sel   = bank_sel_q;
    assign bus.busy       = (state != ST_IDLE) | swap_pending;
    assign bus.layer_done = layer_done_q;

endmodule

// File: tb/tb_unet_fmap_buffer.sv
// Self-checking bench for unet_fmap_buffer. It uses a table of IP read vectors
// and scoreboard queues for the IP read data and the drain data.
module tb_unet_fmap_buffer;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    unet_fmap_buffer_if #(.ADDR_W(15), .DATA_W(12)) bus ();

    unet_fmap_buffer #(.ADDR_W(15), .DATA_W(12), .DEPTH(24576)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [14:0] adr;
        logic        re;
        logic        ck;
        logic [11:0] exp_q;
    } vec_t;

    vec_t        vecs [19];
    logic [11:0] exp_q_sb  [$];
    logic [11:0] exp_dr_sb [$];

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.in_radr  = v.adr;
        bus.in_re    = v.re;
        bus.in_clken = v.ck;
        exp_q_sb.push_back(v.exp_q);
        @(posedge clk);
        @(negedge clk);
        checkOutput("in_q", {20'd0, bus.in_q}, {20'd0, exp_q_sb.pop_front()});
    endtask

    task automatic ipRead(input logic [14:0] adr, input logic [11:0] expv);
        vec_t v;
        v.adr = adr; v.re = 1'b1; v.ck = 1'b1; v.exp_q = expv;
        applyStimulus(v);
    endtask

    task automatic loadWords(input int len, input int n, input logic [11:0] base);
        bus.ld_start = 1'b1;
        bus.ld_len   = 16'(len);
        step();
        bus.ld_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = base + 12'(i);
            step();
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic drainRun(input int len, input logic [11:0] base, input logic [3:0] pat,
                            input int swap_at, input logic bank_before,
                            output int first_k, output int last_k);
        int          k;
        logic        stalled;
        logic [11:0] hold;
        bus.dr_start = 1'b1;
        bus.dr_len   = 16'(len);
        for (int i = 0; i < len; i++)
            exp_dr_sb.push_back(base + 12'(i));
        step();
        bus.dr_start = 1'b0;
        first_k = -1;
        last_k  = -1;
        k       = 0;
        stalled = 1'b0;
        hold    = '0;
        while (exp_dr_sb.size() != 0 && k < 200) begin
            k++;
            bus.dr_ready = pat[(k-1) % 4];
            bus.swap     = (k == swap_at);
            @(negedge clk);
            if (swap_at > 0 && k == swap_at + 1) begin
                checkOutput("bank_sel_held", {31'd0, bus.bank_sel}, {31'd0, bank_before});
                checkOutput("busy_swap_pend", {31'd0, bus.busy}, 32'd1);
            end
            if (bus.dr_valid) begin
                if (first_k < 0)
                    first_k = k;
                if (stalled)
                    checkOutput("dr_stable", {20'd0, bus.dr_data}, {20'd0, hold});
                if (bus.dr_ready) begin
                    checkOutput("dr_data", {20'd0, bus.dr_data}, {20'd0, exp_dr_sb.pop_front()});
                    stalled = 1'b0;
                    last_k  = k;
                end else begin
                    hold    = bus.dr_data;
                    stalled = 1'b1;
                end
            end
            step();
        end
        bus.dr_ready = 1'b0;
        bus.swap     = 1'b0;
        if (exp_dr_sb.size() != 0) begin
            checkOutput("dr_timeout", exp_dr_sb.size(), 32'd0);
            exp_dr_sb.delete();
        end
    endtask

    initial begin
        int fk;
        int lk;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.in_radr = '0; bus.in_re = 0; bus.in_clken = 0; bus.in_triosy_lz = 0;
        bus.out_wadr = '0; bus.out_d = '0; bus.out_we = 0; bus.out_clken = 0; bus.out_triosy_lz = 0;
        bus.ld_start = 0; bus.ld_len = '0; bus.ld_valid = 0; bus.ld_data = '0;
        bus.dr_start = 0; bus.dr_len = '0; bus.dr_ready = 0;
        bus.swap = 0;

        // Table of IP reads after the 16-word load, with hold rows at the end
        for (int i = 0; i < 16; i++) begin
            vecs[i].adr = 15'(i); vecs[i].re = 1'b1; vecs[i].ck = 1'b1; vecs[i].exp_q = 12'(i + 1);
        end
        vecs[16].adr = 15'd3; vecs[16].re = 1'b1; vecs[16].ck = 1'b0; vecs[16].exp_q = 12'h010;
        vecs[17].adr = 15'd5; vecs[17].re = 1'b0; vecs[17].ck = 1'b1; vecs[17].exp_q = 12'h010;
        vecs[18].adr = 15'd7; vecs[18].re = 1'b1; vecs[18].ck = 1'b1; vecs[18].exp_q = 12'h008;

        // Reset state
        #12;
        checkOutput("rst_in_q", {20'd0, bus.in_q}, 32'd0);
        checkOutput("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        checkOutput("rst_dr_valid", {31'd0, bus.dr_valid}, 32'd0);
        checkOutput("rst_flags", {28'd0, bus.bank_sel, bus.busy, bus.layer_done, bus.err}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Load 16 words into bank A, then read them back through the IP port
        bus.ld_start = 1'b1;
        bus.ld_len   = 16'd16;
        step();
        bus.ld_start = 1'b0;
        @(negedge clk);
        checkOutput("ld_ready_on", {31'd0, bus.ld_ready}, 32'd1);
        checkOutput("busy_load", {31'd0, bus.busy}, 32'd1);
        step();
        for (int i = 0; i < 16; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 12'(i + 1);
            step();
        end
        bus.ld_valid = 1'b0;
        @(negedge clk);
        checkOutput("ld_ready_off", {31'd0, bus.ld_ready}, 32'd0);
        checkOutput("busy_after_load", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 19; i++)
            applyStimulus(vecs[i]);
        bus.in_re = 1'b0;

        // IP writes 0xA00+i to the OUT bank, signals done, then drains at full rate
        step();
        for (int i = 0; i < 8; i++) begin
            bus.out_wadr = 15'(i);
            bus.out_d    = 12'hA00 + 12'(i);
            bus.out_we   = 1'b1;
            bus.out_clken = 1'b1;
            step();
        end
        bus.out_we = 1'b0;
        bus.out_triosy_lz = 1'b1;
        step();
        bus.out_triosy_lz = 1'b0;
        @(negedge clk);
        checkOutput("layer_done_set", {31'd0, bus.layer_done}, 32'd1);
        step();
        drainRun(8, 12'hA00, 4'b1111, 0, 1'b0, fk, lk);
        checkOutput("dr_first_cycle", fk, 32'd2);
        checkOutput("dr_back_to_back", lk - fk + 1, 32'd8);
        @(negedge clk);
        checkOutput("busy_after_drain", {31'd0, bus.busy}, 32'd0);

        // Drain again with backpressure 1,0,0,1
        step();
        drainRun(8, 12'hA00, 4'b1001, 0, 1'b0, fk, lk);
        @(negedge clk);
        checkOutput("busy_after_stall_drain", {31'd0, bus.busy}, 32'd0);

        // Swap during a drain takes effect only when the drain finishes
        step();
        drainRun(8, 12'hA00, 4'b1111, 4, 1'b0, fk, lk);
        @(negedge clk);
        checkOutput("bank_sel_swapped", {31'd0, bus.bank_sel}, 32'd1);
        checkOutput("layer_done_clr", {31'd0, bus.layer_done}, 32'd0);
        checkOutput("busy_after_swap", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 8; i++)
            ipRead(15'(i), 12'hA00 + 12'(i));
        bus.in_re = 1'b0;

        // A swap and ld_start in the same IDLE cycle perform the swap only
        step();
        bus.swap     = 1'b1;
        bus.ld_start = 1'b1;
        bus.ld_len   = 16'd4;
        step();
        bus.swap     = 1'b0;
        bus.ld_start = 1'b0;
        @(negedge clk);
        checkOutput("swap_win_bank", {31'd0, bus.bank_sel}, 32'd0);
        checkOutput("swap_win_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        step();
        @(negedge clk);
        checkOutput("swap_win_busy", {31'd0, bus.busy}, 32'd0);

        // A zero-length load never raises busy
        step();
        bus.ld_start = 1'b1;
        bus.ld_len   = 16'd0;
        step();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("zero_len_busy", {28'd0, bus.busy, bus.ld_ready, 2'b00}, 32'd0);
            step();
        end

        // Reset in the middle of a load. Partial data must stay in the RAM.
        ipRead(15'd1, 12'h002);
        bus.in_re = 1'b0;
        bus.out_triosy_lz = 1'b1;
        bus.swap = 1'b1;
        step();
        bus.out_triosy_lz = 1'b0;
        bus.swap = 1'b0;
        loadWords(10, 3, 12'h300);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_in_q", {20'd0, bus.in_q}, 32'd0);
        checkOutput("mid_rst_dr_data", {20'd0, bus.dr_data}, 32'd0);
        checkOutput("mid_rst_flags", {26'd0, bus.ld_ready, bus.dr_valid, bus.bank_sel,
                                      bus.busy, bus.layer_done, bus.err}, 32'd0);
        step();
        rst = 1'b0;
        step();
        bus.swap = 1'b1;
        step();
        bus.swap = 1'b0;
        for (int i = 0; i < 3; i++)
            ipRead(15'(i), 12'h300 + 12'(i));
        bus.in_re = 1'b0;

`ifdef UNET_FMAP_BUF_BOUNDS_EN
        // Out-of-range IP accesses raise err and read back as zero
        step();
        bus.out_wadr  = 15'd24576;
        bus.out_d     = 12'hFFF;
        bus.out_we    = 1'b1;
        bus.out_clken = 1'b1;
        step();
        bus.out_we = 1'b0;
        @(negedge clk);
        checkOutput("oob_wr_err", {31'd0, bus.err}, 32'd1);
        ipRead(15'd0, 12'h300);
        ipRead(15'd24576, 12'h000);
        bus.in_re = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
